// File: rtl/j1_uart_io_if.sv
// rtl/j1_uart_io_if.sv - I/O strobe bus between the J1 core and its peripherals
interface j1_uart_io_if #(
  parameter int WIDTH = 32
);
  logic             io_rd;
  logic             io_wr;
  logic [15:0]      io_addr;
  logic [WIDTH-1:0] io_dout;
  logic [WIDTH-1:0] io_din;

  // Core side drives strobes, address and write data; peripheral returns read data
  modport master (output io_rd, io_wr, io_addr, io_dout, input io_din);
  modport slave  (input io_rd, io_wr, io_addr, io_dout, output io_din);
endinterface

// File: rtl/j1_uart_io.sv
// rtl/j1_uart_io.sv - memory-mapped 8N1 UART with TX FIFO, RX holding register and baud divisor
module j1_uart_io #(
  parameter int          WIDTH         = 32,
  parameter int          TX_DEPTH_LOG2 = 2,
  parameter logic [15:0] DIV_RESET     = 16'd217
) (
  input  logic        clk,
  input  logic        reset,
  j1_uart_io_if.slave io,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int          DEPTH       = 1 << TX_DEPTH_LOG2;
  localparam int          PW          = TX_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [15:0] ADDR_DATA   = 16'h1000;
  localparam logic [15:0] ADDR_STATUS = 16'h2000;
  localparam logic [15:0] ADDR_DIV    = 16'h4000;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Register-side state
  logic [WIDTH-1:0] din_q, din_d;
  logic [15:0]      div_q, div_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;

  // TX FIFO: pointers carry one extra bit so full and empty are distinguishable
  logic [7:0]       fifo_q [DEPTH];
  logic [7:0]       fifo_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, fifo_full;

  // TX shifter
  uart_state_e      tx_state_q, tx_state_d;
  logic [15:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_q, tx_d;
  logic             tx_pop;

  // RX deserializer; sync[0..1] is the synchronizer, sync[2] the previous sample for edge detect
  logic [2:0]       rx_sync_q, rx_sync_d;
  uart_state_e      rx_state_q, rx_state_d;
  logic [15:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_wait_q, rx_wait_d;
  logic             rx_deliver, rx_frame_err;
  logic             rx_line, rx_prev;

  logic             wr_data, wr_div, rd_data, rd_status;
  logic [7:0]       status;

  assign wr_data    = io.io_wr && (io.io_addr == ADDR_DATA);
  assign wr_div     = io.io_wr && (io.io_addr == ADDR_DIV);
  assign rd_data    = io.io_rd && (io.io_addr == ADDR_DATA);
  assign rd_status  = io.io_rd && (io.io_addr == ADDR_STATUS);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                      (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

  assign status     = {3'b000, ferr_q, fifo_empty && (tx_state_q == S_IDLE),
                       overrun_q, rx_valid_q, !fifo_full};

  assign rx_line    = rx_sync_q[1];
  assign rx_prev    = rx_sync_q[2];

  assign io.io_din  = din_q;
  assign uart_tx    = tx_q;

  // TX FIFO update; a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (tx_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_data && (!fifo_full || tx_pop)) begin
      fifo_d[wr_ptr_q[PW-2:0]] = io.io_dout[7:0];
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
  end

  // TX FSM: every state lasts divisor cycles; the divisor is reloaded at each bit boundary
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_q[rd_ptr_q[PW-2:0]];
          tx_cnt_d   = div_q - 16'd1;
          tx_d       = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_DATA;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
          tx_cnt_d   = div_q - 16'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_q[rd_ptr_q[PW-2:0]];
            tx_cnt_d   = div_q - 16'd1;
            tx_d       = 1'b0;
            tx_state_d = S_START;
          end else begin
            tx_d       = 1'b1;
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  // RX FSM: sample mid-bit; a bad stop bit parks in STOP until the line returns high
  always_comb begin
    rx_sync_d    = {rx_sync_q[1:0], uart_rx};
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_wait_d    = rx_wait_q;
    rx_deliver   = 1'b0;
    rx_frame_err = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev && !rx_line) begin
          rx_state_d = S_START;
          rx_cnt_d   = (div_q >> 1) - 16'd1;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_line) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = 3'd0;
            rx_cnt_d   = div_q - 16'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          rx_cnt_d   = div_q - 16'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_wait_q) begin
          if (rx_line) begin
            rx_wait_d  = 1'b0;
            rx_state_d = S_IDLE;
          end
        end else if (rx_cnt_q == 16'd0) begin
          if (rx_line) begin
            rx_deliver = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_frame_err = 1'b1;
            rx_wait_d    = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Register file: read capture, read side effects, divisor writes and RX delivery
  always_comb begin
    din_d      = din_q;
    div_d      = div_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = ferr_q;
    if (io.io_rd) begin
      case (io.io_addr)
        ADDR_DATA:   din_d = {{(WIDTH-8){1'b0}}, rx_byte_q};
        ADDR_STATUS: din_d = {{(WIDTH-8){1'b0}}, status};
        ADDR_DIV:    din_d = {{(WIDTH-16){1'b0}}, div_q};
        default:     din_d = '0;
      endcase
    end
    if (rd_data) rx_valid_d = 1'b0;
    if (rd_status) begin
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
    end
    if (wr_div) div_d = (io.io_dout[15:0] < 16'd4) ? 16'd4 : io.io_dout[15:0];
    if (rx_frame_err) ferr_d = 1'b1;
    if (rx_deliver) begin
      if (rx_valid_q && !rd_data) begin
        overrun_d = 1'b1;
      end else begin
        rx_byte_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q      <= '0;
      div_q      <= DIV_RESET;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
      rx_sync_q  <= 3'b111;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_wait_q  <= 1'b0;
    end else begin
      din_q      <= din_d;
      div_q      <= div_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_wait_q  <= rx_wait_d;
    end
  end

endmodule
